uart_io_master: RTL and testbench

UART-driven initiator for the j1 I/O bus: receives framed command bytes from the `buart` receiver, issues single-cycle `io_wr` / `io_rd` strobes with address and data exactly as the j1 core does, and returns results through the `buart` transmitter. It lets a host peek and poke every I/O-mapped peripheral in `top` (LEDs, GPIO, misc.in) without CPU involvement. `top` muxes its bus outputs with the j1 bus whenever `active` is high.

---
 rtl/uart_io_master.sv | 187 ++++++++++++++++++
 tb/tb_uart_io_master.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_io_master.sv
// UART-driven initiator for the j1 I/O bus: host frames become
// io_wr/io_rd strobes, results go back through the transmitter.
module uart_io_master #(
  parameter int unsigned READ_LAT = 1,
  parameter logic [15:0] TIMEOUT  = 16'd50000
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_rd,
  input  logic        tx_busy,
  output logic        tx_wr,
  output logic [7:0]  tx_data,
  output logic        io_wr,
  output logic        io_rd,
  output logic [15:0] mem_addr,
  output logic [15:0] dout,
  input  logic [15:0] io_din,
  output logic        active
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_GET,
    S_EXEC_W,
    S_EXEC_R,
    S_WAIT_R,
    S_SEND_HI,
    S_SEND_LO,
    S_ACK
  } state_t;

  localparam logic [7:0] OP_W    = 8'h57;
  localparam logic [7:0] OP_R    = 8'h52;
  localparam logic [7:0] ACK_B   = 8'h4B;
  localparam logic [7:0] LAT_MAX = 8'(READ_LAT - 1);

  state_t      state_q, state_d;
  logic        op_w_q, op_w_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] to_q, to_d;
  logic [7:0]  lat_q, lat_d;
  logic        rx_guard_q, rx_guard_d;
  logic        tx_guard_q, tx_guard_d;
  logic [7:0]  rd_lo_q, rd_lo_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] dout_q, dout_d;
  logic        io_wr_q, io_wr_d;
  logic        io_rd_q, io_rd_d;
  logic        active_q, active_d;
  logic        rx_take, tx_give, tx_state;

  // Guards come out of reset set so no strobe fires right after release.
  always_comb begin
    tx_state = (state_q == S_ACK) || (state_q == S_SEND_HI)
            || (state_q == S_SEND_LO);
    rx_take  = rx_valid && !rx_guard_q
            && ((state_q == S_IDLE) || (state_q == S_GET));
    tx_give  = tx_state && !tx_busy && !tx_guard_q;
  end

  always_comb begin
    state_d    = state_q;
    op_w_d     = op_w_q;
    cnt_d      = cnt_q;
    to_d       = '0;
    lat_d      = lat_q;
    rx_guard_d = rx_take;
    tx_guard_d = tx_give;
    rd_lo_d    = rd_lo_q;
    tx_data_d  = tx_data_q;
    mem_addr_d = mem_addr_q;
    dout_d     = dout_q;
    io_wr_d    = 1'b0;
    io_rd_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_take && (rx_data == OP_W || rx_data == OP_R)) begin
          state_d = S_CMD;
          op_w_d  = (rx_data == OP_W);
        end
      end
      S_CMD: begin
        state_d = S_GET;
        cnt_d   = '0;
      end
      S_GET: begin
        if (rx_take) begin
          cnt_d = cnt_q + 2'd1;
          case (cnt_q)
            2'd0:    mem_addr_d[15:8] = rx_data;
            2'd1:    mem_addr_d[7:0]  = rx_data;
            2'd2:    dout_d[15:8]     = rx_data;
            default: dout_d[7:0]      = rx_data;
          endcase
          if (op_w_q && cnt_q == 2'd3) begin
            state_d = S_EXEC_W;
            io_wr_d = 1'b1;
          end else if (!op_w_q && cnt_q == 2'd1) begin
            state_d = S_EXEC_R;
            io_rd_d = 1'b1;
          end
        end else if (to_q == TIMEOUT - 16'd1) begin
          state_d = S_IDLE;
        end else begin
          to_d = to_q + 16'd1;
        end
      end
      S_EXEC_W: begin
        state_d   = S_ACK;
        tx_data_d = ACK_B;
      end
      S_EXEC_R: begin
        state_d = S_WAIT_R;
        lat_d   = '0;
      end
      S_WAIT_R: begin
        if (lat_q == LAT_MAX) begin
          state_d   = S_SEND_HI;
          rd_lo_d   = io_din[7:0];
          tx_data_d = io_din[15:8];
        end else begin
          lat_d = lat_q + 8'd1;
        end
      end
      S_SEND_HI: begin
        if (tx_give) begin
          state_d   = S_SEND_LO;
          tx_data_d = rd_lo_q;
        end
      end
      S_SEND_LO,
      S_ACK: begin
        if (tx_give) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    active_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q    <= S_IDLE;
      op_w_q     <= 1'b0;
      cnt_q      <= '0;
      to_q       <= '0;
      lat_q      <= '0;
      rx_guard_q <= 1'b1;
      tx_guard_q <= 1'b1;
      rd_lo_q    <= '0;
      tx_data_q  <= '0;
      mem_addr_q <= '0;
      dout_q     <= '0;
      io_wr_q    <= 1'b0;
      io_rd_q    <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_w_q     <= op_w_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
      lat_q      <= lat_d;
      rx_guard_q <= rx_guard_d;
      tx_guard_q <= tx_guard_d;
      rd_lo_q    <= rd_lo_d;
      tx_data_q  <= tx_data_d;
      mem_addr_q <= mem_addr_d;
      dout_q     <= dout_d;
      io_wr_q    <= io_wr_d;
      io_rd_q    <= io_rd_d;
      active_q   <= active_d;
    end
  end

  assign rx_rd    = rx_take;
  assign tx_wr    = tx_give;
  assign tx_data  = tx_data_q;
  assign io_wr    = io_wr_q;
  assign io_rd    = io_rd_q;
  assign mem_addr = mem_addr_q;
  assign dout     = dout_q;
  assign active   = active_q;

endmodule

// File: tb/tb_uart_io_master.sv
// Scoreboard bench for uart_io_master: byte-level receiver/transmitter
// models feed frames; a negedge monitor checks every bus and tx strobe.
module tb_uart_io_master;

  localparam logic [15:0] TO = 16'd40;

  logic        clk = 1'b0;
  logic        resetq = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_rd;
  logic        tx_busy = 1'b0;
  logic        tx_wr;
  logic [7:0]  tx_data;
  logic        io_wr;
  logic        io_rd;
  logic [15:0] mem_addr;
  logic [15:0] dout;
  logic [15:0] io_din = 16'hDEAD;
  logic        active;

  uart_io_master #(.READ_LAT(1), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .resetq   (resetq),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_rd    (rx_rd),
    .tx_busy  (tx_busy),
    .tx_wr    (tx_wr),
    .tx_data  (tx_data),
    .io_wr    (io_wr),
    .io_rd    (io_rd),
    .mem_addr (mem_addr),
    .dout     (dout),
    .io_din   (io_din),
    .active   (active)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] a;
    logic [15:0] d;
  } ev_t;

  localparam logic [1:0] K_WR = 2'd0;
  localparam logic [1:0] K_RD = 2'd1;
  localparam logic [1:0] K_TX = 2'd2;

  ev_t         exp_q[$];
  logic [7:0]  rx_fifo[$];
  int          checks = 0;
  int          failures = 0;
  int          rx_rd_cnt = 0;
  int          busy_cnt = 0;
  logic        force_busy = 1'b0;
  logic        rx_pend = 1'b0;
  logic [15:0] rd_val = 16'h0000;
  logic        saw_rx_rd = 1'b0;
  logic        saw_tx_wr = 1'b0;
  logic        saw_io_rd = 1'b0;

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name, input logic [15:0] v);
    checks++;
    failures++;
    $display("FAIL %s unexpected strobe value=%h", name, v);
  endtask

  // Monitor: sample mid-cycle, pop the scoreboard on every strobe.
  always @(negedge clk) begin
    ev_t e;
    if (!resetq) begin
      saw_rx_rd = 1'b0;
      saw_tx_wr = 1'b0;
      saw_io_rd = 1'b0;
    end else begin
      saw_rx_rd = rx_rd;
      saw_tx_wr = tx_wr;
      saw_io_rd = io_rd;
      if (io_wr && io_rd) chk("wr_rd_excl", 16'd1, 16'd0);
      if (rx_rd) begin
        rx_rd_cnt++;
        chk("rx_valid_at_rd", 16'(rx_valid), 16'd1);
      end
      if (io_wr) begin
        if (exp_q.size() == 0) unexpected("io_wr", mem_addr);
        else begin
          e = exp_q.pop_front();
          chk("io_wr_kind", 16'(e.kind), 16'(K_WR));
          chk("io_wr_addr", mem_addr, e.a);
          chk("io_wr_dout", dout, e.d);
        end
      end
      if (io_rd) begin
        if (exp_q.size() == 0) unexpected("io_rd", mem_addr);
        else begin
          e = exp_q.pop_front();
          chk("io_rd_kind", 16'(e.kind), 16'(K_RD));
          chk("io_rd_addr", mem_addr, e.a);
        end
      end
      if (tx_wr) begin
        chk("tx_busy_at_wr", 16'(tx_busy), 16'd0);
        if (exp_q.size() == 0) unexpected("tx_wr", 16'(tx_data));
        else begin
          e = exp_q.pop_front();
          chk("tx_kind", 16'(e.kind), 16'(K_TX));
          chk("tx_data", 16'(tx_data), e.d);
        end
      end
    end
  end

  // Receiver, transmitter and peripheral models, driven just after the edge.
  always @(posedge clk) begin
    #1;
    if (!resetq) begin
      rx_fifo.delete();
      rx_valid = 1'b0;
      rx_pend  = 1'b0;
      busy_cnt = 0;
      io_din   = 16'hDEAD;
    end else begin
      if (rx_pend) begin
        rx_valid = 1'b0;
        rx_pend  = 1'b0;
      end else if (saw_rx_rd) begin
        rx_pend = 1'b1;
      end else if (!rx_valid && rx_fifo.size() != 0) begin
        rx_data  = rx_fifo.pop_front();
        rx_valid = 1'b1;
      end
      io_din = saw_io_rd ? rd_val : 16'hDEAD;
      if (saw_tx_wr) busy_cnt = 3;
      else if (busy_cnt > 0) busy_cnt--;
    end
    tx_busy = force_busy || (busy_cnt > 0);
  end

  task automatic frame_w(input logic [15:0] a, input logic [15:0] d);
    rx_fifo.push_back(8'h57);
    rx_fifo.push_back(a[15:8]);
    rx_fifo.push_back(a[7:0]);
    rx_fifo.push_back(d[15:8]);
    rx_fifo.push_back(d[7:0]);
    exp_q.push_back('{K_WR, a, d});
    exp_q.push_back('{K_TX, 16'h0000, 16'h004B});
  endtask

  task automatic frame_r(input logic [15:0] a, input logic [15:0] v,
                         input logic [15:0] hi, input logic [15:0] lo);
    rd_val = v;
    rx_fifo.push_back(8'h52);
    rx_fifo.push_back(a[15:8]);
    rx_fifo.push_back(a[7:0]);
    exp_q.push_back('{K_RD, a, 16'h0000});
    exp_q.push_back('{K_TX, 16'h0000, hi});
    exp_q.push_back('{K_TX, 16'h0000, lo});
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((rx_fifo.size() != 0 || rx_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain"}, 16'(n < 500), 16'd1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || rx_fifo.size() != 0 || rx_valid
            || active) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, 16'(n < 3000), 16'd1);
    chk({name, "_idle"}, 16'(active), 16'd0);
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_rx_rd"}, 16'(rx_rd), 16'd0);
    chk({name, "_tx_wr"}, 16'(tx_wr), 16'd0);
    chk({name, "_tx_data"}, 16'(tx_data), 16'd0);
    chk({name, "_io_wr"}, 16'(io_wr), 16'd0);
    chk({name, "_io_rd"}, 16'(io_rd), 16'd0);
    chk({name, "_mem_addr"}, mem_addr, 16'd0);
    chk({name, "_dout"}, dout, 16'd0);
    chk({name, "_active"}, 16'(active), 16'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench watchdog");
  end

  initial begin
    int c0;
    #1 resetq = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    resetq = 1'b1;
    repeat (3) @(negedge clk);

    frame_w(16'h0004, 16'h1234);
    wait_done("write");

    frame_r(16'h2000, 16'h0013, 16'h0000, 16'h0013);
    wait_done("read");

    force_busy = 1'b1;
    frame_r(16'h0010, 16'hA55A, 16'h00A5, 16'h005A);
    repeat (30) @(negedge clk);
    chk("busy_pending", 16'(exp_q.size()), 16'd2);
    chk("busy_active", 16'(active), 16'd1);
    repeat (100) @(negedge clk);
    chk("busy_still", 16'(exp_q.size()), 16'd2);
    force_busy = 1'b0;
    wait_done("busy");

    rx_fifo.push_back(8'h57);
    rx_fifo.push_back(8'h00);
    rx_fifo.push_back(8'h04);
    wait_drain("to");
    chk("to_active_mid", 16'(active), 16'd1);
    repeat (int'(TO) + 10) @(negedge clk);
    chk("to_active_after", 16'(active), 16'd0);
    frame_r(16'h0040, 16'hBEEF, 16'h00BE, 16'h00EF);
    wait_done("to_read");

    c0 = rx_rd_cnt;
    rx_fifo.push_back(8'hAA);
    wait_drain("bad");
    repeat (5) @(negedge clk);
    chk("bad_rx_rd", 16'(rx_rd_cnt - c0), 16'd1);
    chk("bad_active", 16'(active), 16'd0);
    frame_r(16'h0003, 16'h0102, 16'h0001, 16'h0002);
    wait_done("bad_read");

    rx_fifo.push_back(8'h57);
    rx_fifo.push_back(8'h12);
    rx_fifo.push_back(8'h34);
    rx_fifo.push_back(8'h56);
    wait_drain("mid");
    repeat (2) @(negedge clk);
    chk("mid_active", 16'(active), 16'd1);
    resetq = 1'b0;
    @(negedge clk);
    chk_reset("mid_rst");
    resetq = 1'b1;
    repeat (30) @(negedge clk);
    chk("mid_after_active", 16'(active), 16'd0);

    frame_w(16'h0008, 16'hCAFE);
    frame_r(16'h0008, 16'h7E81, 16'h007E, 16'h0081);
    wait_done("b2b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
